// File: rtl/popcount_bcd_seq.sv
// Handshaked popcount -> double-dabble BCD sequencer: counts one bit per cycle,
// converts the count to packed 4-digit BCD, and holds the result until the next request.
module popcount_bcd_seq #(
    parameter int DATA_W = 9,
    parameter int BIN_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [BIN_W-1:0]  count,
    output logic [15:0]       bcd
);

    localparam int MAX_N = (DATA_W > BIN_W) ? DATA_W : BIN_W;
    localparam int ITR_W = $clog2(MAX_N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [DATA_W-1:0]  shreg;
    logic [BIN_W-1:0]   acc;
    logic [BIN_W-1:0]   bin_w;
    logic [15:0]        bcd_w;
    logic [ITR_W-1:0]   itr;

    logic [BIN_W-1:0]   acc_next;
    logic [15:0]        bcd_adj;
    logic [15:0]        bcd_shift;
    logic [BIN_W-1:0]   bin_shift;
    logic               last_bit;
    logic               last_itr;

    assign acc_next = acc + BIN_W'(shreg[0]);
    assign last_bit = (itr == ITR_W'(DATA_W - 1));
    assign last_itr = (itr == ITR_W'(BIN_W - 1));

    // Add-3 correction on every digit >= 5 before the shift, so the doubling carries in decimal.
    always_comb begin
        bcd_adj = bcd_w;
        for (int i = 0; i < 4; i++) begin
            if (bcd_w[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_w[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_shift = {bcd_adj[14:0], bin_w[BIN_W-1]};
    assign bin_shift = bin_w << 1;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = S_CONVERT;
                end
            end
            S_CONVERT: begin
                busy = 1'b1;
                if (last_itr) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // acc keeps the final popcount through CONVERT, so it feeds count directly;
    // outputs load on the last conversion edge so they are already valid during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            acc   <= '0;
            bin_w <= '0;
            bcd_w <= '0;
            itr   <= '0;
            count <= '0;
            bcd   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg <= din;
                        acc   <= '0;
                        itr   <= '0;
                    end
                end
                S_COUNT: begin
                    acc   <= acc_next;
                    shreg <= shreg >> 1;
                    itr   <= itr + ITR_W'(1);
                    if (last_bit) begin
                        bin_w <= acc_next;
                        bcd_w <= '0;
                        itr   <= '0;
                    end
                end
                S_CONVERT: begin
                    bcd_w <= bcd_shift;
                    bin_w <= bin_shift;
                    itr   <= itr + ITR_W'(1);
                    if (last_itr) begin
                        count <= acc;
                        bcd   <= bcd_shift;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_bcd_seq.sv
// Self-checking bench for popcount_bcd_seq: directed table, multi-cycle corner sequences,
// and random words checked against a digit-arithmetic reference model.
module tb_popcount_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  din;
    logic        busy;
    logic        done;
    logic [13:0] count;
    logic [15:0] bcd;

    logic        start32;
    logic [31:0] din32;
    logic        busy32;
    logic        done32;
    logic [13:0] count32;
    logic [15:0] bcd32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    popcount_bcd_seq #(.DATA_W(9), .BIN_W(14)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .count (count),
        .bcd   (bcd)
    );

    popcount_bcd_seq #(.DATA_W(32), .BIN_W(14)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .start (start32),
        .din   (din32),
        .busy  (busy32),
        .done  (done32),
        .count (count32),
        .bcd   (bcd32)
    );

    typedef struct {
        logic [8:0]  din;
        logic [13:0] exp_count;
        logic [15:0] exp_bcd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int popc(input logic [31:0] w, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(w[i]);
        return c;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One request on the 9-bit instance; cycle i is the i-th negedge after the accepting edge.
    task automatic run9(input logic [8:0] d, output int t_done, output int pulses,
                        output int busy_n, output logic [13:0] c, output logic [15:0] b);
        @(negedge clk);
        din   = d;
        start = 1'b1;
        t_done = -1; pulses = 0; busy_n = 0; c = '0; b = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                pulses++;
                if (t_done < 0) begin
                    t_done = i; c = count; b = bcd;
                end
            end
        end
    endtask

    task automatic run32(input logic [31:0] d, output int t_done, output int pulses,
                         output logic [13:0] c, output logic [15:0] b);
        @(negedge clk);
        din32   = d;
        start32 = 1'b1;
        t_done = -1; pulses = 0; c = '0; b = '0;
        for (int i = 1; i <= 55; i++) begin
            @(negedge clk);
            if (i == 1) start32 = 1'b0;
            if (done32) begin
                pulses++;
                if (t_done < 0) begin
                    t_done = i; c = count32; b = bcd32;
                end
            end
        end
    endtask

    initial begin
        vec_t        vecs[7];
        int          t_done, pulses, busy_n;
        logic [13:0] c;
        logic [15:0] b;
        int          d_times[$];
        int          d_counts[$];
        logic [31:0] w;
        int          n;

        vecs[0] = '{9'b101101000, 14'd4, 16'h0004};
        vecs[1] = '{9'h1FF,       14'd9, 16'h0009};
        vecs[2] = '{9'h000,       14'd0, 16'h0000};
        vecs[3] = '{9'h155,       14'd5, 16'h0005};
        vecs[4] = '{9'h0AA,       14'd4, 16'h0004};
        vecs[5] = '{9'h100,       14'd1, 16'h0001};
        vecs[6] = '{9'h0FE,       14'd7, 16'h0007};

        // Reset held together with start: reset must win.
        rst = 1'b1; start = 1'b1; din = 9'h1FF; start32 = 1'b0; din32 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_count", count, 14'd0);
        check("reset_bcd", bcd, 16'h0000);
        check("reset_busy32", busy32, 1'b0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_after_reset", busy, 1'b0);

        // First run: full latency and busy window.
        run9(9'b101101000, t_done, pulses, busy_n, c, b);
        check("first_latency", t_done, 24);
        check("first_pulses", pulses, 1);
        check("first_busy_cycles", busy_n, 24);
        check("first_count", c, 14'd4);
        check("first_bcd", b, 16'h0004);
        check("first_count_held", count, 14'd4);

        foreach (vecs[k]) begin
            run9(vecs[k].din, t_done, pulses, busy_n, c, b);
            check($sformatf("vec%0d_latency", k), t_done, 24);
            check($sformatf("vec%0d_pulses", k), pulses, 1);
            check($sformatf("vec%0d_count", k), c, vecs[k].exp_count);
            check($sformatf("vec%0d_bcd", k), b, vecs[k].exp_bcd);
        end

        // start held high, din alternating per run: one result every 25 cycles.
        @(negedge clk);
        din = 9'h001; start = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (done) begin
                d_times.push_back(i);
                d_counts.push_back(int'(count));
                din = (din == 9'h001) ? 9'h0FF : 9'h001;
            end
        end
        start = 1'b0;
        check("held_pulses", d_times.size(), 3);
        if (d_times.size() == 3) begin
            check("held_t0", d_times[0], 24);
            check("held_t1", d_times[1], 49);
            check("held_t2", d_times[2], 74);
            check("held_c0", d_counts[0], 1);
            check("held_c1", d_counts[1], 8);
            check("held_c2", d_counts[2], 1);
        end
        repeat (30) @(negedge clk);

        // Starts during busy (incl. DONE) ignored; din change after capture ignored.
        @(negedge clk);
        din = 9'h0F0; start = 1'b1;
        t_done = -1; pulses = 0; busy_n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                pulses++;
                if (t_done < 0) begin
                    t_done = i; c = count; b = bcd;
                end
            end
            if (i == 2) din = 9'h1FF;
            start = (i == 5 || i == 15 || i == 24);
        end
        start = 1'b0;
        check("ign_pulses", pulses, 1);
        check("ign_latency", t_done, 24);
        check("ign_busy_cycles", busy_n, 24);
        check("ign_count", c, 14'd4);
        check("ign_bcd", b, 16'h0004);

        // Reset in cycle 14 (mid-CONVERT) aborts the run.
        @(negedge clk);
        din = 9'h1FF; start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_count", count, 14'd0);
        check("abort_bcd", bcd, 16'h0000);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run9(9'h007, t_done, pulses, busy_n, c, b);
        check("post_abort_latency", t_done, 24);
        check("post_abort_count", c, 14'd3);
        check("post_abort_bcd", b, 16'h0003);

        // Wide instance: 32 set bits -> BCD 32 at cycle 47.
        run32(32'hFFFF_FFFF, t_done, pulses, c, b);
        check("w32_latency", t_done, 47);
        check("w32_pulses", pulses, 1);
        check("w32_count", c, 14'd32);
        check("w32_bcd", b, 16'h0032);

        for (int k = 0; k < 20; k++) begin
            w = 32'($urandom);
            run9(w[8:0], t_done, pulses, busy_n, c, b);
            n = popc(w, 9);
            check($sformatf("rnd9_%0d_latency", k), t_done, 24);
            check($sformatf("rnd9_%0d_count", k), c, 14'(n));
            check($sformatf("rnd9_%0d_bcd", k), b, to_bcd(n));
        end

        for (int k = 0; k < 8; k++) begin
            w = 32'($urandom);
            run32(w, t_done, pulses, c, b);
            n = popc(w, 32);
            check($sformatf("rnd32_%0d_latency", k), t_done, 47);
            check($sformatf("rnd32_%0d_count", k), c, 14'(n));
            check($sformatf("rnd32_%0d_bcd", k), b, to_bcd(n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/popcount_bcd_seq.md
# popcount_bcd_seq

Sequential controller that schedules the popcount → binary-to-BCD → 4-digit display path. On a `start` request it captures a `DATA_W`-bit input word and counts its set bits serially, one bit per cycle. It then converts the count to packed BCD with an iterative shift-add-3 (double-dabble) loop of `BIN_W` cycles. Finally it loads the result into a held output register that drives the 4-digit 7-segment display driver's `bcd` input. It replaces a free-running combinational chain with a handshaked, one-result-per-request sequence.

## Interface
- `DATA_W`, default 9: width of the input word to popcount; legal range 1..9999.
- `BIN_W`, default 14: width of the binary count and the number of conversion iterations; must satisfy 2^BIN_W > DATA_W.
- `clk`  in  1: single system clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request; sampled only in IDLE.
- `din`  in  DATA_W: word to count; captured on the accepted `start` cycle.
- `busy`  out  1: high in COUNT, CONVERT and DONE.
- `done`  out  1: one-cycle pulse in DONE.
- `count`  out  BIN_W: popcount of the last completed word; held between requests.
- `bcd`  out  16: packed BCD of `count`, with the thousands digit in [15:12] and the units digit in [3:0]; held between requests.

## Operation
- **Registers:**
  - `shreg` (DATA_W): shift copy of `din`.
  - `acc` (BIN_W): popcount accumulator.
  - `bin_w` (BIN_W): conversion binary shifter.
  - `bcd_w` (16): conversion BCD shifter.
  - `itr`: iteration counter, wide enough for max(DATA_W, BIN_W).
  - Output registers `count` and `bcd`.
- **FSM states:** IDLE, COUNT, CONVERT, DONE.
- **IDLE:**
  - If `start`=1: `shreg`←`din`, `acc`←0, `itr`←0, go to COUNT.
  - Otherwise stay in IDLE.
- **COUNT, per cycle:**
  - `acc`←`acc`+`shreg[0]`; `shreg`←`shreg`>>1; `itr`←`itr`+1.
  - When `itr`=DATA_W-1: `bin_w`←final acc (including this cycle's bit), `bcd_w`←0, `itr`←0, go to CONVERT.
- **CONVERT, per cycle:**
  - First, every nibble of `bcd_w` with value ≥5 gets +3.
  - Then `{bcd_w,bin_w}` shifts left by 1 as one 16+BIN_W vector; the MSB of `bin_w` enters `bcd_w[0]`.
  - `itr`←`itr`+1.
  - After the BIN_W-th iteration, go to DONE.
- **DONE:**
  - `count`←converted binary value; `bcd`←final `bcd_w`.
  - `done`=1 for exactly this cycle, then go to IDLE.
- **Width rules:**
  - `acc` never exceeds DATA_W, and DATA_W < 2^BIN_W, so there is no wrap.
  - BCD values above 9999 are outside the legal parameter range; no saturation logic.
- **Busy handling:** `start` while `busy`=1 is ignored. It is not queued and does not change `din` capture. The DONE cycle also ignores `start`; the next request is accepted in IDLE one cycle later.
- **`din` timing:** `din` changes after capture have no effect on the running operation.
- **Reset:** `rst`=1 in any state, including mid-COUNT or mid-CONVERT, forces the following on the next edge:
  - state IDLE;
  - `busy`=0, `done`=0;
  - `count`=0, `bcd`=16'h0000;
  - `acc`, `shreg`, `bin_w`, `bcd_w`, `itr` all cleared.
- **Reset priority:** `rst` has priority over `start` in the same cycle.

## Timing
- Start accepted at edge E0.
  - COUNT occupies cycles E1..E(DATA_W).
  - CONVERT occupies cycles E(DATA_W+1)..E(DATA_W+BIN_W).
  - DONE is at E(DATA_W+BIN_W+1).
- **Defaults:** `done` and the new `bcd` are visible 24 cycles after the start edge.
- **Throughput:** one result per DATA_W+BIN_W+2 cycles with `start` held high. IDLE lasts 1 cycle between runs.
- **`busy`:** rises the cycle after start acceptance and falls the cycle after DONE.
- **Output updates:** `count` and `bcd` update only in DONE; they are stable for the whole of the next run.
- **Reset values:** `busy`=0, `done`=0, `count`=0, `bcd`=0.

## Test plan
- Default parameters, reset, then `din`=9'b101101000, `start` pulse → `done` pulses exactly 24 cycles later, `count`=4, `bcd`=16'h0004; `busy` is high for cycles 1..24.
- `din`=9'h1FF → `count`=9, `bcd`=16'h0009. Then `din`=9'h000 → `count`=0, `bcd`=16'h0000, with `done` still pulsing once.
- Hold `start`=1 continuously with `din` alternating 9'h001 / 9'h0FF → results 1 and 8 on successive `done` pulses spaced 25 cycles apart; no extra pulses appear.
- `start` pulses at cycles 5, 15 and 24 after an accepted start → all ignored. Exactly one `done`, and the result reflects the original `din` even though `din` changed after capture.
- Assert `rst` mid-CONVERT (cycle 14 of a run) → next cycle `busy`=0, `bcd`=0, `count`=0, and no `done` ever appears for the aborted run. A new `start` then completes normally.
- Parameters DATA_W=32, BIN_W=14, `din`=32'hFFFFFFFF → `count`=32, `bcd`=16'h0032, `done` at cycle 47.
